map_server: RTL and testbench

MAP_SERVER -- requirements
Module: map_server

---
 rtl/map_server.sv | 182 ++++++++++++++++++
 tb/tb_map_server.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/map_server.sv
`default_nettype none
// ============================================================================
// Module   : map_server
// Purpose  : Tile-map store: single-port RAM shared by a priority video read
//            port and a queued object read/write port, with power-up clear.
// Revision : 1.0
// ============================================================================
module map_server #(
    parameter int                 ADDR_W      = 12,
    parameter int                 DATA_W      = 8,
    parameter logic [DATA_W-1:0]  CLEAR_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              obj_req,
    input  logic              obj_write,
    input  logic [ADDR_W-1:0] obj_position,
    input  logic [DATA_W-1:0] obj_sprite_write,
    output logic [DATA_W-1:0] obj_sprite_read,
    output logic              obj_ready,
    output logic              obj_overrun,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_position,
    output logic [DATA_W-1:0] vid_sprite,
    output logic              vid_valid,
    output logic              busy
);

    localparam int                c_DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = '1;

    typedef enum logic [1:0] {
        S_CLEAR    = 2'd0,
        S_IDLE     = 2'd1,
        S_OBJ_PEND = 2'd2,
        S_OBJ_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic                r_pend;
    logic                r_hold_write;
    logic [ADDR_W-1:0]   r_hold_pos;
    logic [DATA_W-1:0]   r_hold_data;
    logic                r_done_rd;
    logic [DATA_W-1:0]   r_obj_rd;
    logic                r_obj_ready;
    logic                r_overrun;
    logic                r_vid_valid;
    logic                r_vid_clear;
    logic                r_busy;
    logic [DATA_W-1:0]   r_mem [c_DEPTH];
    logic [DATA_W-1:0]   r_ram_q;

    logic                w_obj_take;
    logic                w_obj_ovr;
    logic                w_obj_go;
    logic                w_acc_write;
    logic [ADDR_W-1:0]   w_acc_pos;
    logic [DATA_W-1:0]   w_acc_data;
    logic                w_ram_we;
    logic                w_ram_re;
    logic [ADDR_W-1:0]   w_ram_addr;
    logic [DATA_W-1:0]   w_ram_wdata;

    // A request is accepted only when nothing is held; anything else is an overrun.
    assign w_obj_take  = obj_req && ((r_state == S_IDLE) || ((r_state == S_CLEAR) && !r_pend));
    assign w_obj_ovr   = obj_req && !w_obj_take;
    assign w_obj_go    = !vid_req && (((r_state == S_IDLE) && obj_req) || (r_state == S_OBJ_PEND));
    assign w_acc_write = (r_state == S_IDLE) ? obj_write        : r_hold_write;
    assign w_acc_pos   = (r_state == S_IDLE) ? obj_position     : r_hold_pos;
    assign w_acc_data  = (r_state == S_IDLE) ? obj_sprite_write : r_hold_data;

    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_re    = 1'b0;
        w_ram_addr  = vid_position;
        w_ram_wdata = w_acc_data;
        if (!reset) begin
            if (r_state == S_CLEAR) begin
                w_ram_we    = 1'b1;
                w_ram_addr  = r_clr_cnt;
                w_ram_wdata = CLEAR_VALUE;
            end else if (vid_req) begin
                w_ram_re = 1'b1;
            end else if (w_obj_go) begin
                w_ram_addr = w_acc_pos;
                w_ram_we   = w_acc_write;
                w_ram_re   = !w_acc_write;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_mem[w_ram_addr] <= w_ram_wdata;
        end
        if (reset) begin
            r_ram_q <= '0;
        end else if (w_ram_re) begin
            r_ram_q <= r_mem[w_ram_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_CLEAR;
            r_clr_cnt    <= '0;
            r_pend       <= 1'b0;
            r_hold_write <= 1'b0;
            r_hold_pos   <= '0;
            r_hold_data  <= '0;
            r_done_rd    <= 1'b0;
            r_obj_rd     <= '0;
            r_obj_ready  <= 1'b0;
            r_overrun    <= 1'b0;
            r_vid_valid  <= 1'b0;
            r_vid_clear  <= 1'b0;
            r_busy       <= 1'b1;
        end else begin
            r_vid_valid <= vid_req;
            r_vid_clear <= (r_state == S_CLEAR);
            r_obj_ready <= 1'b0;
            if (w_obj_ovr) begin
                r_overrun <= 1'b1;
            end
            if (w_obj_take) begin
                r_hold_write <= obj_write;
                r_hold_pos   <= obj_position;
                r_hold_data  <= obj_sprite_write;
            end
            case (r_state)
                S_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (w_obj_take) begin
                        r_pend <= 1'b1;
                    end
                    if (r_clr_cnt == c_LAST_ADDR) begin
                        r_busy  <= 1'b0;
                        r_pend  <= 1'b0;
                        r_state <= (r_pend || w_obj_take) ? S_OBJ_PEND : S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (obj_req) begin
                        if (!vid_req) begin
                            r_state     <= S_OBJ_DONE;
                            r_obj_ready <= 1'b1;
                            r_done_rd   <= !obj_write;
                        end else begin
                            r_state <= S_OBJ_PEND;
                        end
                    end
                end
                S_OBJ_PEND: begin
                    if (!vid_req) begin
                        r_state     <= S_OBJ_DONE;
                        r_obj_ready <= 1'b1;
                        r_done_rd   <= !r_hold_write;
                    end
                end
                S_OBJ_DONE: begin
                    if (r_done_rd) begin
                        r_obj_rd <= r_ram_q;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_CLEAR;
            endcase
        end
    end

    // Read data is shown straight from the RAM output in the ready cycle, then held.
    assign obj_sprite_read = ((r_state == S_OBJ_DONE) && r_done_rd) ? r_ram_q : r_obj_rd;
    assign obj_ready       = r_obj_ready;
    assign obj_overrun     = r_overrun;
    assign vid_sprite      = r_vid_clear ? CLEAR_VALUE : r_ram_q;
    assign vid_valid       = r_vid_valid;
    assign busy            = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_map_server.sv
`default_nettype none
// ============================================================================
// Module   : tb_map_server
// Purpose  : Directed and mixed stimulus for map_server against a cycle model.
// Revision : 1.0
// ============================================================================
module tb_map_server;

    localparam int c_DEPTH = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        obj_req = 1'b0;
    logic        obj_write = 1'b0;
    logic [11:0] obj_position = '0;
    logic [7:0]  obj_sprite_write = '0;
    logic [7:0]  obj_sprite_read;
    logic        obj_ready;
    logic        obj_overrun;
    logic        vid_req = 1'b0;
    logic [11:0] vid_position = '0;
    logic [7:0]  vid_sprite;
    logic        vid_valid;
    logic        busy;

    int checks = 0;
    int errors = 0;

    map_server dut (
        .clk              (clk),
        .reset            (reset),
        .obj_req          (obj_req),
        .obj_write        (obj_write),
        .obj_position     (obj_position),
        .obj_sprite_write (obj_sprite_write),
        .obj_sprite_read  (obj_sprite_read),
        .obj_ready        (obj_ready),
        .obj_overrun      (obj_overrun),
        .vid_req          (vid_req),
        .vid_position     (vid_position),
        .vid_sprite       (vid_sprite),
        .vid_valid        (vid_valid),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: memory array, clear countdown, one held request.
    logic [7:0]  m_mem [c_DEPTH];
    int          m_clr;
    logic        m_pend, m_ready, m_nready, m_ovr, m_vv;
    logic        m_w;
    logic [11:0] m_a;
    logic [7:0]  m_d, m_rd, m_vs;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) m_mem[i] = 8'd0;
            m_clr = c_DEPTH; m_pend = 0; m_ready = 0; m_ovr = 0;
            m_rd = 0; m_vv = 0; m_vs = 0;
        end else begin
            m_nready = 0;
            m_vv = vid_req;
            if (vid_req) m_vs = m_mem[vid_position];
            if (obj_req) begin
                if (m_pend || m_ready) m_ovr = 1;
                else begin
                    m_pend = 1; m_w = obj_write; m_a = obj_position; m_d = obj_sprite_write;
                end
            end
            if (m_pend && m_clr == 0 && !vid_req) begin
                if (m_w) m_mem[m_a] = m_d;
                else     m_rd = m_mem[m_a];
                m_pend = 0;
                m_nready = 1;
            end
            if (m_clr > 0) m_clr--;
            m_ready = m_nready;
        end
        #1;
        chk("busy", busy, m_clr > 0);
        chk("vid_valid", vid_valid, m_vv);
        if (m_vv) chk("vid_sprite", vid_sprite, m_vs);
        chk("obj_ready", obj_ready, m_ready);
        chk("obj_sprite_read", obj_sprite_read, m_rd);
        chk("obj_overrun", obj_overrun, m_ovr);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic obj_op(input logic w, input logic [11:0] a, input logic [7:0] d,
                          input int vcyc, output int lat, output logic [7:0] rd);
        obj_req = 1; obj_write = w; obj_position = a; obj_sprite_write = d;
        vid_req = (vcyc > 0); vid_position = 12'($urandom_range(4095));
        lat = 0; rd = 0;
        while (lat < 50) begin
            tick;
            lat++;
            obj_req = 0;
            vid_req = (lat < vcyc);
            vid_position = 12'($urandom_range(4095));
            if (obj_ready) begin
                rd = obj_sprite_read;
                break;
            end
        end
        vid_req = 0;
        tick;
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        while (n < 5000) begin
            tick;
            n++;
            if (!busy) break;
        end
    endtask

    logic [11:0] pick [4] = '{12'h304, 12'h010, 12'h3F3, 12'h0AA};

    initial begin
        int lat, n, rdy;
        logic [7:0] rd;

        repeat (3) tick;
        chk("reset_busy", busy, 1);
        chk("reset_sprite_read", obj_sprite_read, 0);

        // Clear phase with video reads, one queued write and one overrun.
        reset = 0;
        n = 0;
        while (n < 5000) begin
            tick;
            n++;
            obj_req = (n == 100) || (n == 150);
            obj_write = 1; obj_position = (n == 100) ? 12'h010 : 12'h020; obj_sprite_write = 8'h5A;
            vid_req = (n < 4000) && (n % 3 == 0);
            vid_position = 12'($urandom_range(4095));
            if (!busy) break;
        end
        chk("clear_cycles", n, 4096);
        tick;
        chk("clr_pend_ready", obj_ready, 1);
        tick;
        chk("clr_pend_once", obj_ready, 0);
        chk("clr_overrun", obj_overrun, 1);

        obj_op(0, 12'h3F3, 8'h00, 0, lat, rd);
        chk("rd3f3_data", rd, 8'h00);
        obj_op(1, 12'h304, 8'h61, 0, lat, rd);
        chk("wr304_lat", lat, 1);
        obj_op(0, 12'h304, 8'h00, 0, lat, rd);
        chk("rd304_lat", lat, 1);
        chk("rd304_data", rd, 8'h61);
        obj_op(0, 12'h010, 8'h00, 0, lat, rd);
        chk("rd010_data", rd, 8'h5A);
        obj_op(0, 12'h304, 8'h00, 3, lat, rd);
        chk("vidprio_lat", lat, 4);
        chk("vidprio_data", rd, 8'h61);

        // Second request while the first is held behind video traffic.
        obj_req = 1; obj_write = 0; obj_position = 12'h304; vid_req = 1; vid_position = 12'h010;
        tick;
        obj_req = 1; obj_position = 12'h010;
        tick;
        obj_req = 0; vid_req = 0;
        rdy = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (obj_ready) begin rdy++; rd = obj_sprite_read; end
        end
        chk("ovr_ready_count", rdy, 1);
        chk("ovr_data", rd, 8'h61);
        chk("ovr_sticky", obj_overrun, 1);

        // Mixed traffic.
        for (int i = 0; i < 300; i++) begin
            obj_req = ($urandom_range(3) == 0);
            obj_write = 1'($urandom_range(1));
            obj_position = pick[$urandom_range(3)];
            obj_sprite_write = 8'($urandom_range(255));
            vid_req = 1'($urandom_range(1));
            vid_position = pick[$urandom_range(3)];
            tick;
        end
        obj_req = 0; vid_req = 0;
        repeat (3) tick;

        // Reset while a write is held pending.
        obj_op(1, 12'h304, 8'h61, 0, lat, rd);
        obj_req = 1; obj_write = 1; obj_position = 12'h304; obj_sprite_write = 8'h01; vid_req = 1;
        tick;
        obj_req = 0;
        rdy = 0;
        tick;
        if (obj_ready) rdy++;
        reset = 1; vid_req = 0;
        tick;
        if (obj_ready) rdy++;
        reset = 0;
        wait_clear(n);
        chk("rst_clear_cycles", n, 4096);
        chk("rst_no_ready", rdy, 0);
        chk("rst_overrun", obj_overrun, 0);
        obj_op(0, 12'h304, 8'h00, 0, lat, rd);
        chk("rst_rd304_lat", lat, 1);
        chk("rst_rd304_data", rd, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
